fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch datapath: owns the PC register, drives the instruction-memory address, and captures the combinationally-read instruction into a fetch output register.
- Applies static prediction: JAL always taken, backward conditional branches taken, JALR and forward branches fall through.
- Presents instructions to decode over a valid/ready handshake, accepts redirects from execute, supports halt, and keeps two performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  XLEN  byte address to instruction memory; equals pc_q.
- imem_inst  in  32  instruction read combinationally from imem_addr in the same cycle.
- out_valid  out  1  fetch output register holds an instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_pc  out  XLEN  PC of the held instruction.
- out_inst  out  32  held instruction.
- out_pred_taken  out  1  prediction applied to the held instruction.
- out_pred_target  out  XLEN  predicted next PC of the held instruction.
- redir_valid  in  1  execute redirect (mispredict, jalr, trap).
- redir_pc  in  XLEN  redirect target.
- halt_req  in  1  stop fetching (level).
- halted  out  1  controller is in HALT.
- perf_fetched  out  32  count of handshakes (out_valid & out_ready).
- perf_redirects  out  32  count of accepted redir_valid cycles.

Behaviour:
- States: RUN, HOLD, HALT.
  - RUN: fetching.
  - HOLD: out_valid=1 and out_ready=0, so output and pc_q are frozen.
  - HALT: no fetch.
- Reset (rst_n=0 at a clock edge): pc_q=RESET_PC, state=RUN, out_valid=0, out_pc/out_inst/out_pred_target=0, out_pred_taken=0, halted=0, both perf counters=0.
- Capture condition: state==RUN, the output slot is free or draining (!out_valid | out_ready), no redirect, and halt_req=0.
- On capture, next edge:
  - out_pc<=pc_q, out_inst<=imem_inst, out_valid<=1.
  - pc_q<=pred_next.
- Latency: an instruction appears on out_* one cycle after its address is driven on imem_addr. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Prediction decode on imem_inst[6:0], with immediates sign-extended and added modulo 2^XLEN:
  - 1101111 (JAL): taken; target = pc_q + J-imm.
  - 1100011 (branch): taken iff imm[12]=1 (backward); target = pc_q + B-imm.
  - Otherwise, including 1100111 (JALR): not taken; target = pc_q + 4.
  - pred_next = target; out_pred_target holds the same value.
- pc_q+4 wraps from FFFF_FFFC to 0000_0000.
- Drain without refill: if out_ready=1 and capture is blocked, out_valid<=0.
- Redirect has the highest priority, over halt, hold and capture:
  - pc_q<={redir_pc[XLEN-1:2],2'b00}; out_valid<=0 (flush); state<=RUN (this also exits HALT); perf_redirects++.
  - A simultaneous out_ready handshake still counts in perf_fetched.
- Halt: with halt_req=1 and no redirect, state<=HALT once the output is empty or draining.
  - In HALT: pc_q is held, out_valid=0, halted=1.
  - Exit HALT on deassertion of halt_req (resume at pc_q) or on a redirect.
- Perf counters wrap at 2^32.
- Reset asserted mid-operation discards all in-flight state regardless of the handshake.

Decomposition:
- Package fetch_pkg holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH;
  - state enum {RUN, HOLD, HALT};
  - RESET_PC default.
- One sub-module, static_predictor: purely combinational. Inputs pc and inst; outputs taken and target. It includes the J/B immediate extraction.

Test Plan:
- Reset, then a straight-line program of NOPs (0x00000013) with out_ready=1 → out_pc sequence 0,4,8,… one per cycle, first out_valid one cycle after rst_n rises; perf_fetched increments each cycle.
- JAL with imm=+16 at PC 0x8 (0x0100006F) → out_pred_taken=1, out_pred_target=0x18, next out_pc=0x18.
- Branches at PC 0x20:
  - BEQ with imm=-8 → predicted taken, target 0x18.
  - BEQ with imm=+8 → not taken, target 0x24.
  - JALR → not taken, target 0x24.
- out_ready=0 for 3 cycles while valid → out_pc/out_inst stable and imem_addr constant. out_ready=1 again → the sequence resumes with no skipped or duplicated PC.
- redir_valid with redir_pc=0x103, issued in the same cycle as halt_req and out_ready=0 → next cycle out_valid=0, imem_addr=0x100, perf_redirects=1, state RUN; the next output has out_pc=0x100.
- halt_req held → halted=1, out_valid=0, imem_addr frozen. Release → fetch resumes at the held PC. Separately, pc_q=0xFFFFFFFC with a NOP → next PC 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // RUN: fetching; HOLD: output stalled by decode; HALT: fetch stopped
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_ctrl_static_predictor.sv
// Static next-PC predictor: JAL taken, backward branches taken, all else pc+4.
module static_predictor
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;

  // Sign-extended J- and B-type immediates
  always_comb begin
    j_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  end

  // Opcode decode; JALR is left to execute to resolve
  always_comb begin
    taken  = 1'b0;
    target = pc + XLEN'(4);
    case (inst[6:0])
      OP_JAL: begin
        taken  = 1'b1;
        target = pc + j_imm;
      end
      OP_BRANCH: begin
        if (inst[31]) begin
          taken  = 1'b1;
          target = pc + b_imm;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC ownership, static prediction, decode handshake.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] pc_q;
  logic            capture_c;
  logic            slot_free_c;
  logic            handshake_c;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            unused_redir_lsb;

  assign imem_addr        = pc_q;
  assign slot_free_c      = !out_valid || out_ready;
  assign handshake_c      = out_valid && out_ready;
  assign unused_redir_lsb = ^redir_pc[1:0];

  static_predictor #(.XLEN(XLEN)) u_pred (
    .pc     (pc_q),
    .inst   (imem_inst),
    .taken  (pred_taken),
    .target (pred_target)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state and capture decision; redirect outranks halt, hold and capture
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    if (redir_valid) begin
      state_d = RUN;
    end else if (state_q == HALT) begin
      state_d = halt_req ? HALT : RUN;
    end else if (halt_req) begin
      state_d = slot_free_c ? HALT : HOLD;
    end else if (slot_free_c) begin
      capture_c = 1'b1;
      state_d   = RUN;
    end else begin
      state_d = HOLD;
    end
  end

  // PC, output slot, halt flag and performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_inst        <= '0;
      out_pred_taken  <= 1'b0;
      out_pred_target <= '0;
      halted          <= 1'b0;
      perf_fetched    <= '0;
      perf_redirects  <= '0;
    end else begin
      if (handshake_c) perf_fetched <= perf_fetched + 32'd1;
      if (redir_valid) begin
        pc_q           <= {redir_pc[XLEN-1:2], 2'b00};
        out_valid      <= 1'b0;
        perf_redirects <= perf_redirects + 32'd1;
      end else if (capture_c) begin
        pc_q            <= pred_target;
        out_valid       <= 1'b1;
        out_pc          <= pc_q;
        out_inst        <= imem_inst;
        out_pred_taken  <= pred_taken;
        out_pred_target <= pred_target;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      halted <= (state_d == HALT);
    end
  end

endmodule
